mem_access_unit: RTL and testbench

Load/store unit that sits directly upstream of the word-organised data memory and converts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. It handles byte-lane extraction with sign/zero extension on loads, read-modify-write merging for sub-word stores, and detection of misaligned or illegal requests. It drives the data memory's `Mem_Write`/`DM_Addr`/`M_W_Data` inputs and consumes its combinational `M_R_Data` output.

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-organised data memory: extracts and extends
// sub-word loads, merges sub-word stores by read-modify-write, flags bad requests.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        Mem_Write,
    output logic [31:0] DM_Addr,
    output logic [31:0] M_W_Data,
    input  logic [31:0] M_R_Data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RMW  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wword_q, wword_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        bad_req_s;

    function automatic logic req_illegal(input logic wr, input logic [2:0] f3);
        logic ill;
        ill = 1'b0;
        if (wr) begin
            case (f3)
                F3_B, F3_H, F3_W: ill = 1'b0;
                default:          ill = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ill = 1'b0;
                default:                        ill = 1'b1;
            endcase
        end
        return ill;
    endfunction

    // funct3[1:0] encodes the access size for both signed and unsigned forms
    function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = |a;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[{a, 3'b000} +: 8];
        half_v = word[{a[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    res = {{24{byte_v[7]}}, byte_v};
            F3_H:    res = {{16{half_v[15]}}, half_v};
            F3_W:    res = word;
            F3_BU:   res = {24'h000000, byte_v};
            F3_HU:   res = {16'h0000, half_v};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] old_w, input logic [31:0] wd);
        logic [31:0] res;
        res = old_w;
        case (f3)
            F3_B:    res[{a, 3'b000} +: 8] = wd[7:0];
            F3_H:    res[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: res = old_w;
        endcase
        return res;
    endfunction

    assign bad_req_s = req_illegal(req_write, req_funct3) | req_misaligned(req_funct3, req_addr[1:0]);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'h0000_0000;
            funct3_q <= 3'b000;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            wword_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            wword_q  <= wword_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        wword_d  = wword_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    err_d    = bad_req_s;
                    if (bad_req_s) begin
                        state_d = ST_RESP;
                    end else if (!req_write) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        wword_d = req_wdata;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rdata_d = load_extract(funct3_q, addr_q[1:0], M_R_Data);
                state_d = ST_RESP;
            end
            ST_RMW: begin
                wword_d = store_merge(funct3_q, addr_q[1:0], M_R_Data, wdata_q);
                state_d = ST_WR;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write enable decodes straight from state so a reset removes it before the edge
    assign Mem_Write = (state_q == ST_WR) && write_q;
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign DM_Addr   = {2'b00, addr_q[31:2]};
    assign M_W_Data  = wword_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory preloaded word[i]=i+1.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, Mem_Write;
    logic [31:0] rsp_rdata, DM_Addr, M_W_Data, M_R_Data;
    logic [31:0] mem [0:255];
    logic        mem_init;
    int          total = 0;
    int          bad = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Mem_Write(Mem_Write), .DM_Addr(DM_Addr), .M_W_Data(M_W_Data),
        .M_R_Data(M_R_Data)
    );

    always #5 clk = ~clk;

    assign M_R_Data = mem[DM_Addr[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i + 1);
        end else if (Mem_Write) begin
            mem[DM_Addr[7:0]] <= M_W_Data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; response timing, write activity and response fields are checked
    task automatic xact(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input int exp_mwc, input int exp_mwk,
                        input logic [31:0] exp_mwd, input logic [31:0] exp_rdata,
                        input logic exp_err);
        int lat, mwc, mwk, rdyh;
        logic [31:0] mwd, rdata;
        logic err;
        lat = 0; mwc = 0; mwk = 0; rdyh = 0; mwd = 32'h0; rdata = 32'h0; err = 1'b0;
        @(negedge clk);
        chk({name, ".ready"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (req_ready) rdyh++;
            if (Mem_Write) begin
                mwc++;
                mwk = k;
                mwd = M_W_Data;
            end
            if (rsp_valid) begin
                lat = k;
                rdata = rsp_rdata;
                err = rsp_err;
                break;
            end
        end
        if (lat == 0) chk({name, ".timeout"}, 32'd0, 32'd1);
        chk({name, ".lat"}, lat, exp_lat);
        chk({name, ".mwcnt"}, mwc, exp_mwc);
        if (exp_mwc != 0) begin
            chk({name, ".mwcyc"}, mwk, exp_mwk);
            chk({name, ".mwdata"}, mwd, exp_mwd);
        end
        chk({name, ".busy_ready"}, rdyh, 32'd0);
        chk({name, ".err"}, {31'h0, err}, {31'h0, exp_err});
        chk({name, ".rdata"}, rdata, exp_rdata);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".ready"}, {31'h0, req_ready}, 32'd1);
        chk({name, ".rsp_valid"}, {31'h0, rsp_valid}, 32'd0);
        chk({name, ".rsp_err"}, {31'h0, rsp_err}, 32'd0);
        chk({name, ".rsp_rdata"}, rsp_rdata, 32'h0);
        chk({name, ".mem_write"}, {31'h0, Mem_Write}, 32'd0);
        chk({name, ".dm_addr"}, DM_Addr, 32'h0);
        chk({name, ".m_w_data"}, M_W_Data, 32'h0);
    endtask

    initial begin
        int mw_seen, rv_seen;
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;
        #1 chk_reset_outputs("por");

        xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        2, 0, 0, 32'h0,        32'h0000_0005, 1'b0);
        xact("sw20",  1'b1, 3'b010, 32'h20, 32'h80FF1234, 2, 1, 1, 32'h80FF1234, 32'h0000_0005, 1'b0);
        xact("lb21",  1'b0, 3'b000, 32'h21, 32'h0,        2, 0, 0, 32'h0,        32'h0000_0012, 1'b0);
        xact("lb23",  1'b0, 3'b000, 32'h23, 32'h0,        2, 0, 0, 32'h0,        32'hFFFF_FF80, 1'b0);
        xact("lhu22", 1'b0, 3'b101, 32'h22, 32'h0,        2, 0, 0, 32'h0,        32'h0000_80FF, 1'b0);
        xact("lh22",  1'b0, 3'b001, 32'h22, 32'h0,        2, 0, 0, 32'h0,        32'hFFFF_80FF, 1'b0);
        xact("lw20",  1'b0, 3'b010, 32'h20, 32'h0,        2, 0, 0, 32'h0,        32'h80FF_1234, 1'b0);
        xact("sb41",  1'b1, 3'b000, 32'h41, 32'h000000AB, 3, 1, 2, 32'h0000AB11, 32'h80FF_1234, 1'b0);
        xact("lw40",  1'b0, 3'b010, 32'h40, 32'h0,        2, 0, 0, 32'h0,        32'h0000_AB11, 1'b0);
        xact("sh62",  1'b1, 3'b001, 32'h62, 32'h1234BEEF, 3, 1, 2, 32'hBEEF0019, 32'h0000_AB11, 1'b0);
        xact("lhu62", 1'b0, 3'b101, 32'h62, 32'h0,        2, 0, 0, 32'h0,        32'h0000_BEEF, 1'b0);
        xact("lh62",  1'b0, 3'b001, 32'h62, 32'h0,        2, 0, 0, 32'h0,        32'hFFFF_BEEF, 1'b0);
        xact("lbu63", 1'b0, 3'b100, 32'h63, 32'h0,        2, 0, 0, 32'h0,        32'h0000_00BE, 1'b0);
        xact("lb60",  1'b0, 3'b000, 32'h60, 32'h0,        2, 0, 0, 32'h0,        32'h0000_0019, 1'b0);

        xact("e_lw06",  1'b0, 3'b010, 32'h06, 32'h0,        1, 0, 0, 32'h0, 32'h0000_0019, 1'b1);
        xact("e_sh03",  1'b1, 3'b001, 32'h03, 32'hFFFF,     1, 0, 0, 32'h0, 32'h0000_0019, 1'b1);
        xact("e_ld011", 1'b0, 3'b011, 32'h10, 32'h0,        1, 0, 0, 32'h0, 32'h0000_0019, 1'b1);
        xact("e_st100", 1'b1, 3'b100, 32'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0, 32'h0000_0019, 1'b1);
        xact("lw10b",   1'b0, 3'b010, 32'h10, 32'h0,        2, 0, 0, 32'h0, 32'h0000_0005, 1'b0);

        // Reset asserted while a half-word store sits in RMW
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h80; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw.ready", {31'h0, req_ready}, 32'd0);
        chk("rmw.mem_write", {31'h0, Mem_Write}, 32'd0);
        rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        mw_seen = 0; rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (Mem_Write) mw_seen++;
            if (rsp_valid) rv_seen++;
        end
        chk("midrst.mw_after", mw_seen, 32'd0);
        chk("midrst.rsp_after", rv_seen, 32'd0);
        xact("lw80", 1'b0, 3'b010, 32'h80, 32'h0, 2, 0, 0, 32'h0, 32'h0000_0021, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
